gray_ptr_rx: RTL and testbench

- Receive-side companion to the binary-to-Gray converter. Takes a Gray-coded pointer or count launched from another clock domain and passes it through an N-flop synchronizer.
- Decodes the synchronized value to binary and reports the step since the previous update.
- Flags any update that violates the single-bit-change Gray property.
- Sits directly downstream of the converter, e.g. the read side of a pointer crossing.

---
 rtl/gray_pkg.sv | 34 +++
 rtl/gray_sync.sv | 30 +++
 rtl/gray_ptr_rx.sv | 90 +++++++++
 tb/tb_gray_ptr_rx.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared Gray-code helpers for the pointer-crossing converter pair.
// Functions work on a fixed-width word; callers zero-extend and size-cast back.
package gray_pkg;

  localparam int GRAY_MIN_VEC_W       = 2;
  localparam int GRAY_MIN_SYNC_STAGES = 2;
  localparam int GRAY_MAX_W           = 32;

  typedef logic [GRAY_MAX_W-1:0] gray_word_t;

  function automatic gray_word_t bin2gray(input gray_word_t b);
    return b ^ (b >> 1);
  endfunction

  // Zero-extended upper bits decode to zero, so the low bits match a narrow decode.
  function automatic gray_word_t gray2bin(input gray_word_t g);
    gray_word_t b;
    b = g;
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic popcount_gt1(input gray_word_t x);
    return |(x & (x - gray_word_t'(1)));
  endfunction

  function automatic logic gray_params_legal(input int vec_w, input int stages);
    return (vec_w >= GRAY_MIN_VEC_W) && (vec_w <= GRAY_MAX_W) &&
           (stages >= GRAY_MIN_SYNC_STAGES);
  endfunction

endpackage

// File: rtl/gray_sync.sv
// Multi-flop synchronizer for a Gray-coded bus arriving from a foreign clock domain.
module gray_sync #(
  parameter int W      = 4,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] sync_r [STAGES];

  // Flop chain; stage 0 is the only flop that samples the asynchronous bus.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) begin
        sync_r[k] <= {W{1'b0}};
      end
    end else begin
      sync_r[0] <= d;
      for (int k = 1; k < STAGES; k++) begin
        sync_r[k] <= sync_r[k-1];
      end
    end
  end

  assign q = sync_r[STAGES-1];

endmodule

// File: rtl/gray_ptr_rx.sv
// Receive side of a Gray pointer crossing: synchronize, decode, report step size
// and flag any update that moved more than one bit.
module gray_ptr_rx
  import gray_pkg::*;
#(
  parameter int VEC_W       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [VEC_W-1:0] gray_i,
  input  logic             clr_err_i,
  output logic [VEC_W-1:0] bin_o,
  output logic [VEC_W-1:0] delta_o,
  output logic             upd_o,
  output logic             err_o
);

  logic [VEC_W-1:0] g_s;
  logic [VEC_W-1:0] prev_r;
  logic [VEC_W-1:0] bin_r;
  logic [VEC_W-1:0] delta_r;
  logic             upd_r;
  logic             err_r;

  logic [VEC_W-1:0] bin_new_s;
  logic [VEC_W-1:0] bin_old_s;
  logic [VEC_W-1:0] delta_s;
  logic             chg_s;
  logic             multi_s;
  logic             err_nxt_s;

  gray_sync #(
    .W      (VEC_W),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (gray_i),
    .q     (g_s)
  );

  // Decode both samples and form the modular step plus the sticky-error next state.
  always_comb begin
    bin_new_s = VEC_W'(gray2bin(gray_word_t'(g_s)));
    bin_old_s = VEC_W'(gray2bin(gray_word_t'(prev_r)));
    chg_s     = (g_s != prev_r);
    multi_s   = popcount_gt1(gray_word_t'(g_s ^ prev_r));
    delta_s   = {VEC_W{1'b0}};
    err_nxt_s = err_r;

    if (chg_s) begin
      delta_s = bin_new_s - bin_old_s;
    end else begin
      delta_s = {VEC_W{1'b0}};
    end

    // A fresh violation outranks a clear arriving on the same edge.
    if (multi_s) begin
      err_nxt_s = 1'b1;
    end else if (clr_err_i) begin
      err_nxt_s = 1'b0;
    end else begin
      err_nxt_s = err_r;
    end
  end

  // Compare stage registers; erroneous steps still update bin/delta/upd.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_r  <= {VEC_W{1'b0}};
      bin_r   <= {VEC_W{1'b0}};
      delta_r <= {VEC_W{1'b0}};
      upd_r   <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      prev_r  <= g_s;
      bin_r   <= bin_new_s;
      delta_r <= delta_s;
      upd_r   <= chg_s;
      err_r   <= err_nxt_s;
    end
  end

  assign bin_o   = bin_r;
  assign delta_o = delta_r;
  assign upd_o   = upd_r;
  assign err_o   = err_r;

endmodule

// File: tb/tb_gray_ptr_rx.sv
// Directed bench for gray_ptr_rx: an edge-indexed history model checked every cycle,
// plus literal expectations at key points of each scenario.
module tb_gray_ptr_rx;

  localparam int W    = 4;
  localparam int S    = 2;
  localparam int MAXE = 256;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] gray_i;
  logic         clr_err_i;
  logic [W-1:0] bin_o;
  logic [W-1:0] delta_o;
  logic         upd_o;
  logic         err_o;

  int tests = 0;
  int fails = 0;

  logic [W-1:0] in_a  [MAXE];
  bit           rst_a [MAXE];
  bit           clr_a [MAXE];
  int           n     = 0;
  bit           err_m = 1'b0;

  int           ce;
  int           eb;
  int           ob;
  logic [W-1:0] gs;
  logic [W-1:0] pv;
  bit           chg;

  always #5 clk = ~clk;

  gray_ptr_rx #(.VEC_W(W), .SYNC_STAGES(S)) dut (
    .clk       (clk),
    .reset     (reset),
    .gray_i    (gray_i),
    .clr_err_i (clr_err_i),
    .bin_o     (bin_o),
    .delta_o   (delta_o),
    .upd_o     (upd_o),
    .err_o     (err_o)
  );

  function automatic logic [W-1:0] to_gray(input int i);
    logic [W-1:0] b;
    b = W'(i);
    return b ^ (b >> 1);
  endfunction

  // Decode by search over all codes, independent of the XOR-chain formulation.
  function automatic int from_gray(input logic [W-1:0] g);
    for (int b = 0; b < 16; b++) begin
      if (to_gray(b) == g) return b;
    end
    return -1;
  endfunction

  function automatic bit rst_at(input int k);
    if (k < 0) return 1'b1;
    return rst_a[k];
  endfunction

  function automatic bit rst_in(input int lo, input int hi);
    for (int k = lo; k <= hi; k++) begin
      if (rst_at(k)) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [W-1:0] in_at(input int k);
    if (k < 0) return 4'd0;
    return in_a[k];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic [W-1:0] g, input bit clr, input bit rst);
    gray_i    = g;
    clr_err_i = clr;
    reset     = rst;
    in_a[n]   = g;
    clr_a[n]  = clr;
    rst_a[n]  = rst;
    @(posedge clk);
    n++;
    #1;
  endtask

  // Per-edge model: value seen by the compare stage is the input S edges back,
  // unless a reset fell inside that window.
  always @(negedge clk) begin
    if (n > 0) begin
      ce = n - 1;
      if (rst_a[ce]) begin
        err_m = 1'b0;
        check("rst_bin", bin_o, 0);
        check("rst_delta", delta_o, 0);
        check("rst_upd", upd_o, 0);
        check("rst_err", err_o, 0);
      end else begin
        gs  = rst_in(ce - S, ce - 1) ? 4'd0 : in_at(ce - S);
        pv  = rst_in(ce - S - 1, ce - 1) ? 4'd0 : in_at(ce - S - 1);
        eb  = from_gray(gs);
        ob  = from_gray(pv);
        chg = (gs != pv);
        if ($countones(gs ^ pv) > 1) err_m = 1'b1;
        else if (clr_a[ce]) err_m = 1'b0;
        check("model_bin", bin_o, eb);
        check("model_upd", upd_o, chg);
        check("model_delta", delta_o, chg ? ((eb - ob + 16) % 16) : 0);
        check("model_err", err_o, err_m);
      end
    end
  end

  initial begin
    reset     = 1'b1;
    gray_i    = 4'd0;
    clr_err_i = 1'b0;

    // Reset and idle
    repeat (3) step(4'b0000, 1'b0, 1'b1);
    repeat (3) step(4'b0000, 1'b0, 1'b0);
    check("idle_bin", bin_o, 0);
    check("idle_upd", upd_o, 0);
    check("idle_err", err_o, 0);

    // Count 0..15 and wrap to 0
    for (int i = 0; i <= 16; i++) step(to_gray(i), 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    check("cnt15_bin", bin_o, 15);
    check("cnt15_delta", delta_o, 1);
    step(4'b0000, 1'b0, 1'b0);
    check("wrap_bin", bin_o, 0);
    check("wrap_delta", delta_o, 1);
    check("wrap_upd", upd_o, 1);
    check("wrap_err", err_o, 0);

    // Multi-bit jump 1 -> 5
    repeat (4) step(4'b0001, 1'b0, 1'b0);
    repeat (3) step(4'b0111, 1'b0, 1'b0);
    check("jump_bin", bin_o, 5);
    check("jump_delta", delta_o, 4);
    check("jump_upd", upd_o, 1);
    check("jump_err", err_o, 1);
    step(4'b0111, 1'b0, 1'b0);
    check("jump_hold_upd", upd_o, 0);
    check("jump_hold_err", err_o, 1);

    // Clear alone, then clear coinciding with a new violation
    step(4'b0111, 1'b1, 1'b0);
    check("clr_err", err_o, 0);
    step(4'b0000, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    step(4'b0000, 1'b1, 1'b0);
    check("setwin_err", err_o, 1);
    check("setwin_bin", bin_o, 0);
    check("setwin_delta", delta_o, 11);

    // Reset in the middle of a count
    for (int i = 1; i <= 11; i++) step(to_gray(i), 1'b0, 1'b0);
    check("pre_rst_bin", bin_o, 9);
    step(to_gray(12), 1'b0, 1'b1);
    check("midrst_bin", bin_o, 0);
    check("midrst_upd", upd_o, 0);
    check("midrst_err", err_o, 0);
    repeat (3) step(4'b0000, 1'b0, 1'b0);
    for (int i = 1; i <= 3; i++) step(to_gray(i), 1'b0, 1'b0);
    repeat (2) step(to_gray(3), 1'b0, 1'b0);
    check("resume_bin", bin_o, 3);
    check("resume_delta", delta_o, 1);
    check("resume_err", err_o, 0);

    // Steady input
    repeat (10) step(4'b1010, 1'b0, 1'b0);
    check("hold_bin", bin_o, 12);
    check("hold_upd", upd_o, 0);
    check("hold_delta", delta_o, 0);

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
